// File: rtl/fpadd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fpadd_unit
// Description : Multi-cycle IEEE-754 single-precision add/subtract unit.
//               Takes the two FP register-file read operands and drives the
//               register-file write port directly. The operation is issued
//               with start and written back LAT cycles later. busy is held
//               for the whole operation so that the control unit can stall.
//               Rounding is truncation. Denormal inputs are flushed to zero.
//               NaN results are canonical (0x7FC00000).
// Ports       : clk, reset_n (async, active-low)
//               start, sub, a, b, dest : issue request and operands
//               busy                   : unit is not idle
//               done, fwe              : one-cycle writeback pulse
//               fwa3, fwd3             : write address / write data
// Revision    : 1.0  initial release
// ============================================================================
module fpadd_unit #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  dest,
    output logic        busy,
    output logic        done,
    output logic        fwe,
    output logic [4:0]  fwa3,
    output logic [31:0] fwd3
);

    // WB is the state that is reached LAT edges after the issue edge.
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ALIGN = 3'd1;
    localparam logic [2:0] c_ADD   = 3'd2;
    localparam logic [2:0] c_NORM  = 3'd3;
    localparam logic [2:0] c_WB    = 3'(LAT);

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    logic [2:0]  r_state, w_next;
    logic [31:0] r_a, r_b;
    logic        r_sub;
    logic [4:0]  r_dest;

    // ALIGN stage results
    logic        r_sign_l, r_sign_s;
    logic [7:0]  r_exp_l;
    logic [23:0] r_man_l, r_man_s;
    logic        r_special;
    logic [31:0] r_special_val;
    // ADD stage result
    logic [24:0] r_sum;
    // writeback registers
    logic [4:0]  r_fwa3;
    logic [31:0] r_fwd3;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE:  w_next = start ? c_ALIGN : c_IDLE;
            c_ALIGN: w_next = c_ADD;
            c_ADD:   w_next = c_NORM;
            c_NORM:  w_next = c_WB;
            default: w_next = c_IDLE;
        endcase
    end

    assign busy = (r_state != c_IDLE);
    assign fwe  = (r_state == c_WB);
    assign done = fwe;
    assign fwa3 = r_fwa3;
    assign fwd3 = r_fwd3;

    // -------------------------------------------------------------- ALIGN
    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb;
    logic [23:0] w_ma, w_mb;
    logic        w_a_ge;
    logic [7:0]  w_diff;
    logic [23:0] w_ms_raw;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [31:0] w_special_val;

    assign w_sa = r_a[31];
    assign w_sb = r_b[31] ^ r_sub;
    assign w_ea = r_a[30:23];
    assign w_eb = r_b[30:23];
    // exponent zero is flushed to zero: no hidden bit, no fraction
    assign w_ma = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_mb = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
    // exponent-then-fraction ordering is a plain compare of {exp, mantissa}
    assign w_a_ge = ({w_ea, w_ma} >= {w_eb, w_mb});
    assign w_diff = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_ms_raw = w_a_ge ? w_mb : w_ma;

    assign w_nan_a = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_nan_b = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_inf_a = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_inf_b = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);

    always_comb begin
        w_special_val = c_QNAN;
        if (w_nan_a || w_nan_b)     w_special_val = c_QNAN;
        else if (w_inf_a && w_inf_b) w_special_val = (w_sa != w_sb) ? c_QNAN : {w_sa, 8'hFF, 23'd0};
        else if (w_inf_a)            w_special_val = {w_sa, 8'hFF, 23'd0};
        else                         w_special_val = {w_sb, 8'hFF, 23'd0};
    end

    // --------------------------------------------------------------- NORM
    logic [4:0]         w_lz;
    logic               w_found;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_n;
    logic [31:0]        w_result;

    // leading-zero count of the 24-bit (no carry) sum
    always_comb begin
        w_lz    = 5'd0;
        w_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!w_found) begin
                if (r_sum[i]) w_found = 1'b1;
                else          w_lz    = w_lz + 5'd1;
            end
        end
    end

    // after the left shift the leading one sits at bit 23 and is dropped,
    // so only the low 23 bits of the sum need to be shifted
    assign w_frac  = r_sum[24] ? r_sum[23:1] : (r_sum[22:0] << w_lz);
    assign w_exp_n = r_sum[24] ? ($signed({2'b00, r_exp_l}) + 10'sd1)
                               : ($signed({2'b00, r_exp_l}) - $signed({5'd0, w_lz}));

    always_comb begin
        w_result = 32'd0;
        if (r_special)                w_result = r_special_val;
        else if (r_sum == 25'd0)      w_result = {r_sign_l & r_sign_s, 31'd0};
        else if (w_exp_n >= 10'sd255) w_result = {r_sign_l, 8'hFF, 23'd0};
        else if (w_exp_n <= 10'sd0)   w_result = 32'd0;
        else                          w_result = {r_sign_l, w_exp_n[7:0], w_frac};
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_sub         <= 1'b0;
            r_dest        <= 5'd0;
            r_sign_l      <= 1'b0;
            r_sign_s      <= 1'b0;
            r_exp_l       <= 8'd0;
            r_man_l       <= 24'd0;
            r_man_s       <= 24'd0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
            r_sum         <= 25'd0;
            r_fwa3        <= 5'd0;
            r_fwd3        <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_sub  <= sub;
                        r_dest <= dest;
                    end
                end
                c_ALIGN: begin
                    r_sign_l      <= w_a_ge ? w_sa : w_sb;
                    r_sign_s      <= w_a_ge ? w_sb : w_sa;
                    r_exp_l       <= w_a_ge ? w_ea : w_eb;
                    r_man_l       <= w_a_ge ? w_ma : w_mb;
                    // bits shifted past the LSB are discarded (truncation)
                    r_man_s       <= (w_diff >= 8'd25) ? 24'd0 : (w_ms_raw >> w_diff);
                    r_special     <= w_nan_a | w_nan_b | w_inf_a | w_inf_b;
                    r_special_val <= w_special_val;
                end
                c_ADD: begin
                    r_sum <= (r_sign_l == r_sign_s) ? ({1'b0, r_man_l} + {1'b0, r_man_s})
                                                    : ({1'b0, r_man_l} - {1'b0, r_man_s});
                end
                c_NORM: begin
                    r_fwa3 <= r_dest;
                    r_fwd3 <= w_result;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpadd_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpadd_unit
// Description : Self-checking bench for fpadd_unit. A reference model tracks
//               issue timing and computes each result from the arithmetic
//               rules. Every cycle is compared against it. Directed vectors
//               carry hand-computed literal results that pin the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fpadd_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  dest = 5'd0;
    logic        busy, done, fwe;
    logic [4:0]  fwa3;
    logic [31:0] fwd3;

    int n_chk  = 0;
    int n_pass = 0;
    int fwe_cnt = 0;

    fpadd_unit #(.LAT(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sub(sub),
        .a(a), .b(b), .dest(dest),
        .busy(busy), .done(done), .fwe(fwe), .fwa3(fwa3), .fwd3(fwd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic: unbounded integers, loop normalisation.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic   sx, sy, sl, ss;
        int     ex, ey, el, es, d, e;
        longint mx, my, ml, ms, mag;
        sx = x[31];
        sy = y[31] ^ s;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
        if (ex == 255 && ey == 255) return (sx != sy) ? 32'h7FC00000 : {sx, 31'h7F800000};
        if (ex == 255) return {sx, 31'h7F800000};
        if (ey == 255) return {sy, 31'h7F800000};
        mx = (ex == 0) ? 64'd0 : (64'h800000 + longint'(x[22:0]));
        my = (ey == 0) ? 64'd0 : (64'h800000 + longint'(y[22:0]));
        if (ex > ey || (ex == ey && mx >= my)) begin
            sl = sx; el = ex; ml = mx; ss = sy; es = ey; ms = my;
        end else begin
            sl = sy; el = ey; ml = my; ss = sx; es = ex; ms = mx;
        end
        d = el - es;
        if (d >= 25) ms = 0;
        else         ms = ms >> d;
        mag = (sl == ss) ? ml + ms : ml - ms;
        if (mag == 0) return {sl & ss, 31'd0};
        e = el;
        while (mag >= 64'h1000000) begin mag = mag >> 1; e++; end
        while (mag <  64'h800000)  begin mag = mag << 1; e--; end
        if (e >= 255) return {sl, 31'h7F800000};
        if (e <= 0)   return 32'd0;
        return {sl, 8'(e), 23'(mag)};
    endfunction

    // Model of issue timing: phase counts edges since the accepted start.
    int          m_phase = 0;
    logic [31:0] m_val = 32'd0;
    logic [4:0]  m_dest = 5'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_val   <= model(a, b, sub);
                m_dest  <= dest;
            end
        end else begin
            m_phase <= (m_phase == 4) ? 0 : m_phase + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (fwe) fwe_cnt++;
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("fwe",  32'(fwe),  32'(m_phase == 4));
        chk("done", 32'(done), 32'(m_phase == 4));
        if (m_phase == 4) begin
            chk("fwa3", 32'(fwa3), 32'(m_dest));
            chk("fwd3", fwd3, m_val);
        end
    end

    task automatic run_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xs, input logic [4:0] xd, input logic [31:0] exp);
        bit seen;
        chk({name, " model"}, model(xa, xb, xs), exp);
        @(negedge clk);
        a = xa; b = xb; sub = xs; dest = xd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); dest = 5'($urandom);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (fwe) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL %s: no fwe within 8 cycles, expected result %h", name, exp);
        end else begin
            chk({name, " fwd3"}, fwd3, exp);
            chk({name, " fwa3"}, 32'(fwa3), 32'(xd));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset fwe",  32'(fwe),  32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset fwa3", 32'(fwa3), 32'd0);
        chk("reset fwd3", fwd3, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("1+2",        32'h3F800000, 32'h40000000, 1'b0, 5'd5,  32'h40400000);
        run_op("1.5-1.5",    32'h3FC00000, 32'h3FC00000, 1'b1, 5'd1,  32'h00000000);
        run_op("-0+-0",      32'h80000000, 32'h80000000, 1'b0, 5'd2,  32'h80000000);
        run_op("-0++0",      32'h80000000, 32'h00000000, 1'b0, 5'd3,  32'h00000000);
        run_op("inf-inf",    32'h7F800000, 32'h7F800000, 1'b1, 5'd4,  32'h7FC00000);
        run_op("nan+1",      32'h7FC00001, 32'h3F800000, 1'b0, 5'd6,  32'h7FC00000);
        run_op("max+max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd7,  32'h7F800000);
        run_op("1+tiny",     32'h3F800000, 32'h30800000, 1'b0, 5'd8,  32'h3F800000);
        run_op("1-tiny",     32'h3F800000, 32'h30800000, 1'b1, 5'd9,  32'h3F800000);
        run_op("3-1",        32'h40400000, 32'h3F800000, 1'b1, 5'd10, 32'h40000000);
        run_op("-2+1",       32'hC0000000, 32'h3F800000, 1'b0, 5'd11, 32'hBF800000);
        run_op("1-(-inf)",   32'h3F800000, 32'hFF800000, 1'b1, 5'd12, 32'h7F800000);
        run_op("underflow",  32'h00800000, 32'h00C00000, 1'b1, 5'd13, 32'h00000000);
        run_op("denorm+1",   32'h00000001, 32'h3F800000, 1'b0, 5'd14, 32'h3F800000);
        run_op("ulp diff",   32'h3F800001, 32'h3F800000, 1'b1, 5'd0,  32'h34000000);

        // start held high across an operation and into the next slot
        @(negedge clk);
        #1 c0 = fwe_cnt;
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; dest = 5'd20; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; dest = 5'($urandom);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("back-to-back fwe count", 32'(fwe_cnt - c0), 32'd2);

        // reset in the middle of an operation
        @(negedge clk);
        #1 c0 = fwe_cnt;
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; dest = 5'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-op reset busy", 32'(busy), 32'd0);
        chk("mid-op reset fwe",  32'(fwe),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("no fwe after reset", 32'(fwe_cnt - c0), 32'd0);

        run_op("after reset", 32'h40000000, 32'h40000000, 1'b0, 5'd31, 32'h40800000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
